mixer_mode_sched: RTL and testbench

- Sequencer for the 16-lane real-output mixer's 2-bit mode register (0 = bypass, 1 = mix by pi/2, 2 = mix by pi/4).
- Accepts timed mode commands over an AXI-Stream-style slave into a small command FIFO and applies them back-to-back with cycle-exact durations.
- Asserts a blanking strobe while the mixer's 2-stage pipeline still holds samples from the old mode.
- Sits between the control-plane command source and the mixer's MODE_REG input.

---
 rtl/mixer_mode_sched_pkg.sv | 19 +
 rtl/mixer_mode_sched_cmd_fifo.sv | 55 +++++
 rtl/mixer_mode_sched.sv | 142 ++++++++++++++
 tb/tb_mixer_mode_sched.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mixer_mode_sched_pkg.sv
// Shared encodings for the mixer mode sequencer: mode values, FSM states, command field layout.
package mixer_sched_pkg;

  localparam logic [1:0] MODE_BYPASS  = 2'd0;
  localparam logic [1:0] MODE_PI2     = 2'd1;
  localparam logic [1:0] MODE_PI4     = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  localparam int MODE_W  = 2;
  localparam int DUR_LSB = 0;

  // The mode field sits directly above the duration field.
  function automatic int mode_lsb(input int dur_w);
    return DUR_LSB + dur_w;
  endfunction

  typedef enum logic [1:0] {IDLE, BLANK, RUN} state_t;

endpackage

// File: rtl/mixer_mode_sched_cmd_fifo.sv
// First-word-fall-through command FIFO; head valid the cycle after the write, registered count.
// Pushes are refused when full (even with a same-cycle pop); flush empties it and overrides push/pop.
module sched_cmd_fifo #(
  parameter int unsigned W     = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_dat,
  input  logic                       i_pop,
  output logic [W-1:0]               o_pop_dat,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_push_ok, w_pop_ok;

  assign o_full    = (r_cnt == FULL_CNT);
  assign o_empty   = (r_cnt == '0);
  assign o_cnt     = r_cnt;
  assign o_pop_dat = r_mem[r_rptr];
  assign w_push_ok = i_push && !o_full && !i_flush;
  assign w_pop_ok  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      if (w_push_ok && !w_pop_ok)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (w_pop_ok && !w_push_ok) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_push_dat;
  end

endmodule

// File: rtl/mixer_mode_sched.sv
// Applies timed mixer MODE_REG commands back-to-back; mode_o moves two cycles after the command write.
// s_cmd_tready drops while the FIFO is full or flush is high; blank_o covers the mixer pipeline after a mode change.
module mixer_mode_sched
  import mixer_sched_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DUR_W     = 16,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       s_cmd_tvalid,
  output logic                       s_cmd_tready,
  input  logic [DUR_W+1:0]           s_cmd_tdata,
  output logic [1:0]                 mode_o,
  output logic                       blank_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH):0]     fifo_cnt_o,
  output logic                       underrun_o,
  output logic                       err_o
);

  localparam int unsigned CMD_W      = DUR_W + MODE_W;
  localparam int          MODE_LSB   = mode_lsb(DUR_W);
  localparam logic [3:0]  BLANK_INIT = 4'(BLANK_CYC);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic [DUR_W-1:0] r_dur_cnt, w_dur_nxt;
  logic [3:0]       r_blank_cnt, w_bcnt_nxt;
  logic             r_blank, r_busy, r_underrun, r_err;
  logic             w_underrun_nxt, w_load, w_pop, w_push, w_full, w_empty;
  logic [1:0]       w_in_mode, w_head_mode;
  logic [DUR_W-1:0] w_head_dur;
  logic [CMD_W-1:0] w_wr_dat, w_rd_dat;

  assign s_cmd_tready = !w_full && !flush;
  assign w_push       = s_cmd_tvalid && s_cmd_tready;
  assign w_in_mode    = s_cmd_tdata[MODE_LSB +: MODE_W];
  // Mode 3 is never stored, so the FSM only ever sees legal modes.
  assign w_wr_dat     = {(w_in_mode == MODE_ILLEGAL) ? MODE_BYPASS : w_in_mode,
                         s_cmd_tdata[DUR_LSB +: DUR_W]};
  assign w_head_mode  = w_rd_dat[MODE_LSB +: MODE_W];
  assign w_head_dur   = w_rd_dat[DUR_LSB +: DUR_W];

  sched_cmd_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .i_flush    (flush),
    .i_push     (w_push),
    .i_push_dat (w_wr_dat),
    .i_pop      (w_pop),
    .o_pop_dat  (w_rd_dat),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_cnt      (fifo_cnt_o)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_mode_nxt     = r_mode;
    w_dur_nxt      = r_dur_cnt;
    w_bcnt_nxt     = r_blank_cnt;
    w_underrun_nxt = 1'b0;
    w_load         = 1'b0;
    w_pop          = 1'b0;
    unique case (r_state)
      IDLE:  w_load = en && !w_empty;
      BLANK: begin
        if (r_blank_cnt == 4'd1) w_state_nxt = RUN;
        else                     w_bcnt_nxt  = r_blank_cnt - 4'd1;
      end
      RUN: begin
        if (r_dur_cnt == '0) begin
          w_load = en && !w_empty;
        end else if (r_dur_cnt == DUR_W'(1)) begin
          if (en && !w_empty) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt    = IDLE;
            w_dur_nxt      = '0;
            w_underrun_nxt = en && w_empty;
          end
        end else begin
          w_dur_nxt = r_dur_cnt - DUR_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_load) begin
      w_pop      = 1'b1;
      w_mode_nxt = w_head_mode;
      w_dur_nxt  = w_head_dur;
      if (w_head_mode != r_mode) begin
        w_state_nxt = BLANK;
        w_bcnt_nxt  = BLANK_INIT;
      end else begin
        w_state_nxt = RUN;
      end
    end
    // Flush aborts everything except the mode already driven to the mixer.
    if (flush) begin
      w_state_nxt    = IDLE;
      w_mode_nxt     = r_mode;
      w_dur_nxt      = '0;
      w_bcnt_nxt     = '0;
      w_underrun_nxt = 1'b0;
      w_pop          = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_mode      <= MODE_BYPASS;
      r_dur_cnt   <= '0;
      r_blank_cnt <= '0;
      r_blank     <= 1'b0;
      r_busy      <= 1'b0;
      r_underrun  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_dur_cnt   <= w_dur_nxt;
      r_blank_cnt <= w_bcnt_nxt;
      r_blank     <= (w_state_nxt == BLANK);
      r_busy      <= (w_state_nxt != IDLE);
      r_underrun  <= w_underrun_nxt;
      if (w_push && (w_in_mode == MODE_ILLEGAL)) r_err <= 1'b1;
    end
  end

  assign mode_o     = r_mode;
  assign blank_o    = r_blank;
  assign busy_o     = r_busy;
  assign underrun_o = r_underrun;
  assign err_o      = r_err;

endmodule

// File: tb/tb_mixer_mode_sched.sv
// Bench for mixer_mode_sched: directed scenarios then random traffic, checked every cycle against a timeline model.
module tb_mixer_mode_sched;

  localparam int DEPTH     = 4;
  localparam int DUR_W     = 16;
  localparam int BLANK_CYC = 2;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             en = 1'b0;
  logic             flush = 1'b0;
  logic             s_cmd_tvalid = 1'b0;
  logic             s_cmd_tready;
  logic [DUR_W+1:0] s_cmd_tdata = '0;
  logic [1:0]       mode_o;
  logic             blank_o, busy_o, underrun_o, err_o;
  logic [2:0]       fifo_cnt_o;

  mixer_mode_sched #(.DEPTH(DEPTH), .DUR_W(DUR_W), .BLANK_CYC(BLANK_CYC)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .flush        (flush),
    .s_cmd_tvalid (s_cmd_tvalid),
    .s_cmd_tready (s_cmd_tready),
    .s_cmd_tdata  (s_cmd_tdata),
    .mode_o       (mode_o),
    .blank_o      (blank_o),
    .busy_o       (busy_o),
    .fifo_cnt_o   (fifo_cnt_o),
    .underrun_o   (underrun_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Timeline model: a loaded command owns a known span of future cycles.
  typedef struct {int mode; int dur;} cmd_t;
  cmd_t q[$];
  int   cyc = 0;
  int   m_mode, m_blank_end, m_last;
  bit   m_active, m_forever, m_und, m_err, m_acc;

  task automatic model_reset();
    q.delete();
    m_mode = 0; m_active = 0; m_forever = 0; m_und = 0; m_err = 0; m_acc = 0;
    m_blank_end = -1; m_last = -1;
  endtask

  task automatic check_outputs();
    check_eq("mode",     mode_o,     m_mode);
    check_eq("blank",    blank_o,    m_active && (cyc <= m_blank_end));
    check_eq("busy",     busy_o,     m_active);
    check_eq("fifo_cnt", fifo_cnt_o, q.size());
    check_eq("underrun", underrun_o, m_und);
    check_eq("err",      err_o,      m_err);
    check_eq("tready",   s_cmd_tready, (q.size() < DEPTH) && !flush);
  endtask

  task automatic model_step();
    int   sz0, b, md;
    bit   can_load;
    cmd_t c;
    sz0 = q.size(); m_und = 0; m_acc = 0;
    if (flush) begin
      q.delete();
      m_active = 0;
    end else begin
      can_load = !m_active || (m_forever ? (cyc > m_blank_end) : (cyc == m_last));
      if (can_load && en && sz0 > 0) begin
        c = q.pop_front();
        b = (c.mode != m_mode) ? BLANK_CYC : 0;
        m_mode = c.mode; m_active = 1; m_forever = (c.dur == 0);
        m_blank_end = cyc + b; m_last = cyc + b + c.dur;
      end else if (m_active && !m_forever && cyc == m_last) begin
        m_active = 0;
        m_und = en && (sz0 == 0);
      end
      if (s_cmd_tvalid && sz0 < DEPTH) begin
        md = int'(s_cmd_tdata[DUR_W+1:DUR_W]);
        if (md == 3) begin m_err = 1; md = 0; end
        c.mode = md; c.dur = int'(s_cmd_tdata[DUR_W-1:0]);
        q.push_back(c);
        m_acc = 1;
      end
    end
    cyc++;
  endtask

  task automatic tick(input bit v, input logic [1:0] md, input int dur, input bit e, input bit f);
    @(posedge clk); #1;
    s_cmd_tvalid = v; s_cmd_tdata = {md, DUR_W'(dur)}; en = e; flush = f;
    @(negedge clk);
    check_outputs();
    model_step();
  endtask

  task automatic send(input logic [1:0] md, input int dur, input bit e);
    int k = 0;
    do begin
      tick(1'b1, md, dur, e, 1'b0);
      k++;
    end while (!m_acc && k < 64);
    check_eq("send_accept", m_acc, 1);
  endtask

  task automatic idle(input int n, input bit e);
    repeat (n) tick(1'b0, 2'd0, 0, e, 1'b0);
  endtask

  initial begin
    bit         hold;
    logic [1:0] hm;
    int         hd;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mode", mode_o, 0);
    check_eq("rst_blank", blank_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_cnt", fifo_cnt_o, 0);
    check_eq("rst_err", err_o, 0);
    @(posedge clk); #2 rstn = 1'b1;

    send(2'd1, 5, 1'b1);
    idle(12, 1'b1);

    send(2'd1, 3, 1'b1); send(2'd1, 4, 1'b1); send(2'd2, 2, 1'b1);
    idle(16, 1'b1);

    send(2'd1, 2, 1'b0); send(2'd2, 3, 1'b0); send(2'd0, 1, 1'b0); send(2'd2, 2, 1'b0);
    repeat (3) tick(1'b1, 2'd1, 4, 1'b0, 1'b0);
    send(2'd1, 4, 1'b1);
    idle(40, 1'b1);

    send(2'd2, 0, 1'b1);
    idle(10, 1'b1);
    send(2'd0, 1, 1'b1);
    idle(6, 1'b1);

    send(2'd3, 4, 1'b1);
    idle(8, 1'b1);

    send(2'd1, 100, 1'b1);
    idle(3, 1'b1);
    send(2'd2, 5, 1'b1); send(2'd0, 7, 1'b1);
    idle(3, 1'b1);
    tick(1'b0, 2'd0, 0, 1'b1, 1'b1);
    idle(4, 1'b1);

    send(2'd2, 3, 1'b1);
    idle(1, 1'b1);
    @(posedge clk); #2;
    check_eq("pre_rst_blank", blank_o, m_active && (cyc <= m_blank_end));
    rstn = 1'b0; #1;
    check_eq("arst_mode", mode_o, 0);
    check_eq("arst_blank", blank_o, 0);
    check_eq("arst_busy", busy_o, 0);
    check_eq("arst_cnt", fifo_cnt_o, 0);
    check_eq("arst_err", err_o, 0);
    check_eq("arst_und", underrun_o, 0);
    model_reset();
    s_cmd_tvalid = 1'b0; flush = 1'b0;
    #2 rstn = 1'b1;

    hold = 0; hm = 2'd0; hd = 0;
    for (int i = 0; i < 3000; i++) begin
      bit e, f;
      int r;
      if (!hold && $urandom_range(0, 2) == 0) begin
        hold = 1;
        hm = 2'($urandom_range(0, 3));
        r = $urandom_range(0, 9);
        hd = (r == 0) ? 0 : (r == 1) ? 1 : int'($urandom_range(2, 8));
      end
      e = ($urandom_range(0, 7) != 0);
      f = ($urandom_range(0, 79) == 0);
      tick(hold, hm, hd, e, f);
      if (m_acc) hold = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
